// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the counter datapath in reset until the PLL lock
// has been stable long enough, then releases reset and enables counting a cycle later.
module pll_lock_sequencer #(
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LOSS_CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  run_req,
    output logic                  rst_out,
    output logic                  cnt_en,
    output logic [2:0]            state,
    output logic                  timeout,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > TIMEOUT_CYCLES) ? STABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W    = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } seq_state_t;

    seq_state_t              state_r;
    seq_state_t              next_state_s;
    logic [TIMER_W-1:0]      timer_r;
    logic [TIMER_W-1:0]      timer_next_s;
    logic                    lock_meta_r;
    logic                    lock_sync_r;
    logic                    rst_out_r;
    logic                    rst_out_next_s;
    logic                    cnt_en_r;
    logic                    cnt_en_next_s;
    logic                    timeout_r;
    logic                    timeout_next_s;
    logic [LOSS_CNT_W-1:0]   loss_count_r;
    logic [LOSS_CNT_W-1:0]   loss_next_s;

    // Next-state decode; priority is run_req drop, then lock event, then timer expiry.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_req) begin
                    next_state_s = ST_WAIT_LOCK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_LOCK: begin
                if (!run_req) begin
                    next_state_s = ST_IDLE;
                end else if (lock_sync_r) begin
                    next_state_s = ST_STABLE;
                end else if (timer_r == TIMEOUT_LAST) begin
                    next_state_s = ST_FAULT;
                end else begin
                    next_state_s = ST_WAIT_LOCK;
                end
            end
            ST_STABLE: begin
                if (!run_req) begin
                    next_state_s = ST_IDLE;
                end else if (!lock_sync_r) begin
                    next_state_s = ST_WAIT_LOCK;
                end else if (timer_r == STABLE_LAST) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_STABLE;
                end
            end
            ST_RUN: begin
                if (!run_req) begin
                    next_state_s = ST_IDLE;
                end else if (!lock_sync_r) begin
                    next_state_s = ST_WAIT_LOCK;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (!run_req) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_FAULT;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Timer, output sequencing, fault flag and lock-loss statistic next values.
    always_comb begin
        timer_next_s   = timer_r;
        rst_out_next_s = 1'b1;
        cnt_en_next_s  = 1'b0;
        timeout_next_s = timeout_r;
        loss_next_s    = loss_count_r;

        if (next_state_s != state_r) begin
            timer_next_s = '0;
        end else if ((state_r == ST_WAIT_LOCK) || (state_r == ST_STABLE)) begin
            timer_next_s = timer_r + TIMER_W'(1);
        end else begin
            timer_next_s = timer_r;
        end

        // Reset drops only once RUN is already held; enable follows a cycle after.
        if ((state_r == ST_RUN) && (next_state_s == ST_RUN)) begin
            rst_out_next_s = 1'b0;
            cnt_en_next_s  = ~rst_out_r;
        end else begin
            rst_out_next_s = 1'b1;
            cnt_en_next_s  = 1'b0;
        end

        if ((state_r == ST_WAIT_LOCK) && (next_state_s == ST_FAULT)) begin
            timeout_next_s = 1'b1;
        end else if ((state_r == ST_FAULT) && (next_state_s == ST_IDLE)) begin
            timeout_next_s = 1'b0;
        end else begin
            timeout_next_s = timeout_r;
        end

        if ((state_r == ST_RUN) && (next_state_s == ST_WAIT_LOCK) && (loss_count_r != '1)) begin
            loss_next_s = loss_count_r + LOSS_CNT_W'(1);
        end else begin
            loss_next_s = loss_count_r;
        end
    end

    // State and output registers, including the two-flop lock synchronizer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            timer_r      <= '0;
            lock_meta_r  <= 1'b0;
            lock_sync_r  <= 1'b0;
            rst_out_r    <= 1'b1;
            cnt_en_r     <= 1'b0;
            timeout_r    <= 1'b0;
            loss_count_r <= '0;
        end else begin
            state_r      <= next_state_s;
            timer_r      <= timer_next_s;
            lock_meta_r  <= pll_locked;
            lock_sync_r  <= lock_meta_r;
            rst_out_r    <= rst_out_next_s;
            cnt_en_r     <= cnt_en_next_s;
            timeout_r    <= timeout_next_s;
            loss_count_r <= loss_next_s;
        end
    end

    assign state      = state_r;
    assign rst_out    = rst_out_r;
    assign cnt_en     = cnt_en_r;
    assign timeout    = timeout_r;
    assign loss_count = loss_count_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: stimulus queues cycle-tagged expected
// output snapshots; a negedge monitor pops and compares them as cycles elapse.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_locked;
    logic       run_req;
    logic       rst_out;
    logic       cnt_en;
    logic [2:0] state;
    logic       timeout;
    logic [1:0] loss_count;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       rst;
        logic       en;
        logic       to;
        logic [1:0] lc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   b, d, e0, c, b3, f, g, h, lc_exp;

    pll_lock_sequencer #(
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(32),
        .LOSS_CNT_W    (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_locked(pll_locked),
        .run_req   (run_req),
        .rst_out   (rst_out),
        .cnt_en    (cnt_en),
        .state     (state),
        .timeout   (timeout),
        .loss_count(loss_count)
    );

    always #5 clk = ~clk;

    // Count rising edges so expectations can be tagged with absolute edge numbers.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int at, input logic [2:0] st, input logic r, input logic e,
                             input logic t, input logic [1:0] lc);
        exp_t x;
        x.cyc = at; x.st = st; x.rst = r; x.en = e; x.to = t; x.lc = lc;
        q.push_back(x);
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor: compare every snapshot whose edge has been reached.
    always @(negedge clk) begin
        exp_t x;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            x = q.pop_front();
            vectors++;
            if (x.cyc < cyc) begin
                miscompares++;
                $display("FAIL stale@%0d: expectation not checked in time (now %0d)", x.cyc, cyc);
            end else if ({state, rst_out, cnt_en, timeout, loss_count} !==
                         {x.st, x.rst, x.en, x.to, x.lc}) begin
                miscompares++;
                $display("FAIL edge%0d: got st=%0d rst=%b en=%b to=%b lc=%0d, want st=%0d rst=%b en=%b to=%b lc=%0d",
                         cyc, state, rst_out, cnt_en, timeout, loss_count,
                         x.st, x.rst, x.en, x.to, x.lc);
            end
        end
    end

    initial begin
        // Reset beats run_req
        reset = 1'b1; run_req = 1'b1; pll_locked = 1'b0;
        expect_at(2, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_to(3);
        reset = 1'b0; run_req = 1'b0; pll_locked = 1'b1;
        expect_at(5, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);

        // Bring-up with lock already present
        b = 7; wait_to(b); run_req = 1'b1;
        expect_at(b+1,  3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b+2,  3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b+9,  3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b+10, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(b+11, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(b+12, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);

        // run_req drop on the same edge lock_s falls: IDLE, no loss counted
        d = b + 14; wait_to(d); pll_locked = 1'b0;
        expect_at(d+2, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_at(d+3, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_to(d+2); run_req = 1'b0;
        wait_to(d+3); pll_locked = 1'b1;

        // One-cycle lock glitch in STABLE restarts the stable timer
        e0 = d + 6; wait_to(e0); run_req = 1'b1;
        expect_at(e0+1,  3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+2,  3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+9,  3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+10, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+11, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+18, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+19, 3'd3, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(e0+20, 3'd3, 1'b0, 1'b0, 1'b0, 2'd0);
        expect_at(e0+21, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        wait_to(e0+7); pll_locked = 1'b0;
        wait_to(e0+8); pll_locked = 1'b1;

        // Lock loss in RUN, then relock
        c = e0 + 23; wait_to(c); pll_locked = 1'b0;
        expect_at(c+2, 3'd3, 1'b0, 1'b1, 1'b0, 2'd0);
        expect_at(c+3, 3'd1, 1'b1, 1'b0, 1'b0, 2'd1);
        b3 = c + 4; wait_to(b3); pll_locked = 1'b1;
        expect_at(b3+2,  3'd1, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(b3+3,  3'd2, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(b3+10, 3'd2, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(b3+11, 3'd3, 1'b1, 1'b0, 1'b0, 2'd1);
        expect_at(b3+12, 3'd3, 1'b0, 1'b0, 1'b0, 2'd1);
        expect_at(b3+13, 3'd3, 1'b0, 1'b1, 1'b0, 2'd1);

        // Four more losses: counter saturates at 3
        f = b3 + 15; lc_exp = 1;
        for (int i = 0; i < 4; i++) begin
            wait_to(f); pll_locked = 1'b0;
            lc_exp = (lc_exp == 3) ? 3 : lc_exp + 1;
            expect_at(f+3, 3'd1, 1'b1, 1'b0, 1'b0, 2'(lc_exp));
            wait_to(f+4); pll_locked = 1'b1;
            expect_at(f+17, 3'd3, 1'b0, 1'b1, 1'b0, 2'(lc_exp));
            f = f + 18;
        end

        // Reset in RUN clears everything, including the synchronizer
        g = f; wait_to(g); reset = 1'b1;
        expect_at(g+1, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_to(g+1); reset = 1'b0;
        expect_at(g+2, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(g+3, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(g+4, 3'd2, 1'b1, 1'b0, 1'b0, 2'd0);
        wait_to(g+4); run_req = 1'b0; pll_locked = 1'b0;
        expect_at(g+5, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);

        // Lock timeout into FAULT, hold, then release via run_req drop
        h = g + 8; wait_to(h); run_req = 1'b1;
        expect_at(h+1,  3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(h+32, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_at(h+33, 3'd4, 1'b1, 1'b0, 1'b1, 2'd0);
        expect_at(h+40, 3'd4, 1'b1, 1'b0, 1'b1, 2'd0);
        wait_to(h+40); run_req = 1'b0;
        expect_at(h+41, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0);

        wait_to(h+44);
        if (q.size() != 0) begin
            miscompares = miscompares + q.size();
            $display("FAIL leftover: %0d expectations never checked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
